// File: rtl/dpd_cap_pkg.sv
// rtl/dpd_cap_pkg.sv - shared types and constants for the DPD capture buffer
// Purpose : capture FSM state encoding and read-address field codes.
// Ports   : none (package).
package dpd_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  // rd_addr[MSB]: which capture buffer
  localparam logic SEL_TX  = 1'b0;
  localparam logic SEL_ORX = 1'b1;

  // rd_addr[0]: which 32-bit half of the 64-bit beat
  localparam logic WORD_I = 1'b0;
  localparam logic WORD_Q = 1'b1;

endpackage

// File: rtl/dpd_cap_ram.sv
// rtl/dpd_cap_ram.sv - 64-bit simple dual-port capture RAM with registered read
// Purpose : one write port, one read port; a read returns the word held
//           before a same-cycle write to the same address.
// Ports   : clk; we/waddr/wdata write port; re/raddr read request;
//           rdata registered read data (valid the cycle after re).
module dpd_cap_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [63:0]           wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [63:0]           rdata
);

  logic [63:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dpd_capture_buffer.sv
// rtl/dpd_capture_buffer.sv - tx/orx sample snapshot engine for DPD adaptation
// Purpose : arms on cap_start, skips cap_delay tx beats, then captures up to
//           cap_len beats of tx and orx into two independent RAMs; serves
//           reads with a fixed 2-cycle latency.
// Ports   : data_clk/data_rstn clock and async active-low reset;
//           tx_in_*/tx_valid, orx_in_*/orx_valid sample beats;
//           cap_start/cap_abort/cap_len/cap_delay control;
//           cap_busy/cap_done/tx_count/orx_count status;
//           rd_req/rd_addr -> rd_data/rd_valid read path.
module dpd_capture_buffer #(
  parameter int BUF_ADDR_WIDTH = 10,
  parameter int DELAY_WIDTH    = 16
) (
  input  logic                      data_clk,
  input  logic                      data_rstn,
  input  logic [31:0]               tx_in_0,
  input  logic [31:0]               tx_in_1,
  input  logic                      tx_valid,
  input  logic [31:0]               orx_in_0,
  input  logic [31:0]               orx_in_1,
  input  logic                      orx_valid,
  input  logic                      cap_start,
  input  logic                      cap_abort,
  input  logic [BUF_ADDR_WIDTH:0]   cap_len,
  input  logic [DELAY_WIDTH-1:0]    cap_delay,
  output logic                      cap_busy,
  output logic                      cap_done,
  output logic [BUF_ADDR_WIDTH:0]   tx_count,
  output logic [BUF_ADDR_WIDTH:0]   orx_count,
  input  logic                      rd_req,
  input  logic [BUF_ADDR_WIDTH+1:0] rd_addr,
  output logic [31:0]               rd_data,
  output logic                      rd_valid
);
  import dpd_cap_pkg::*;

  localparam int AW = BUF_ADDR_WIDTH;
  localparam logic [AW:0]          CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]          CNT_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [DELAY_WIDTH-1:0] DLY_ONE = {{(DELAY_WIDTH-1){1'b0}}, 1'b1};

  cap_state_t             state_q, state_d;
  logic [AW:0]            len_q;
  logic [DELAY_WIDTH-1:0] delay_q;
  logic                   tx_full, orx_full;
  logic                   start_ok, tx_we, orx_we, enter_done;

  assign tx_full  = (tx_count == len_q);
  assign orx_full = (orx_count == len_q);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge data_clk or negedge data_rstn) begin
    if (!data_rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cap_start) begin
          state_d = (cap_delay != '0) ? ST_ARMED : ST_CAPTURE;
        end
      end
      ST_ARMED: begin
        // Leave once the final skipped beat takes the counter to zero.
        if (cap_abort) begin
          state_d = ST_IDLE;
        end else if (tx_valid && (delay_q == DLY_ONE)) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // Abort outranks completion.
        if (cap_abort) begin
          state_d = ST_IDLE;
        end else if (tx_full && orx_full) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    cap_busy   = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    start_ok   = (state_q == ST_IDLE) && cap_start;
    tx_we      = (state_q == ST_CAPTURE) && !cap_abort && tx_valid && !tx_full;
    orx_we     = (state_q == ST_CAPTURE) && !cap_abort && orx_valid && !orx_full;
    enter_done = (state_q == ST_CAPTURE) && (state_d == ST_DONE);
  end

  // ---------------- capture bookkeeping ----------------
  always_ff @(posedge data_clk or negedge data_rstn) begin
    if (!data_rstn) begin
      len_q     <= '0;
      delay_q   <= '0;
      tx_count  <= '0;
      orx_count <= '0;
      cap_done  <= 1'b0;
    end else if (start_ok) begin
      len_q     <= (cap_len == '0) ? CNT_FULL : cap_len;
      delay_q   <= cap_delay;
      tx_count  <= '0;
      orx_count <= '0;
      cap_done  <= 1'b0;
    end else begin
      if ((state_q == ST_ARMED) && tx_valid && (delay_q != '0)) begin
        delay_q <= delay_q - DLY_ONE;
      end
      if (tx_we) begin
        tx_count <= tx_count + CNT_ONE;
      end
      if (orx_we) begin
        orx_count <= orx_count + CNT_ONE;
      end
      if (enter_done) begin
        cap_done <= 1'b1;
      end
    end
  end

  // ---------------- buffers ----------------
  logic [63:0] tx_rdata, orx_rdata;

  dpd_cap_ram #(.ADDR_WIDTH(AW)) u_tx_ram (
    .clk   (data_clk),
    .we    (tx_we),
    .waddr (tx_count[AW-1:0]),
    .wdata ({tx_in_1, tx_in_0}),
    .re    (rd_req),
    .raddr (rd_addr[AW:1]),
    .rdata (tx_rdata)
  );

  dpd_cap_ram #(.ADDR_WIDTH(AW)) u_orx_ram (
    .clk   (data_clk),
    .we    (orx_we),
    .waddr (orx_count[AW-1:0]),
    .wdata ({orx_in_1, orx_in_0}),
    .re    (rd_req),
    .raddr (rd_addr[AW:1]),
    .rdata (orx_rdata)
  );

  // ---------------- read pipeline: RAM stage, then output register ----------------
  logic        rd_req_q, rd_sel_q, rd_word_q;
  logic [63:0] rd_beat;

  assign rd_beat = (rd_sel_q == SEL_TX) ? tx_rdata : orx_rdata;

  always_ff @(posedge data_clk or negedge data_rstn) begin
    if (!data_rstn) begin
      rd_req_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_word_q <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_req_q  <= rd_req;
      rd_sel_q  <= rd_addr[AW+1];
      rd_word_q <= rd_addr[0];
      rd_valid  <= rd_req_q;
      if (rd_req_q) begin
        rd_data <= (rd_word_q == WORD_I) ? rd_beat[31:0] : rd_beat[63:32];
      end
    end
  end

endmodule

// File: tb/tb_dpd_capture_buffer.sv
// tb/tb_dpd_capture_buffer.sv - directed self-checking bench for dpd_capture_buffer
module tb_dpd_capture_buffer;

  logic        data_clk = 1'b0;
  logic        data_rstn;
  logic [31:0] tx_in_0, tx_in_1, orx_in_0, orx_in_1;
  logic        tx_valid, orx_valid;
  logic        cap_start, cap_abort;
  logic [10:0] cap_len;
  logic [15:0] cap_delay;
  logic        cap_busy, cap_done;
  logic [10:0] tx_count, orx_count;
  logic        rd_req;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;

  int errors = 0;
  int checks = 0;

  dpd_capture_buffer #(.BUF_ADDR_WIDTH(10), .DELAY_WIDTH(16)) dut (
    .data_clk  (data_clk),
    .data_rstn (data_rstn),
    .tx_in_0   (tx_in_0),
    .tx_in_1   (tx_in_1),
    .tx_valid  (tx_valid),
    .orx_in_0  (orx_in_0),
    .orx_in_1  (orx_in_1),
    .orx_valid (orx_valid),
    .cap_start (cap_start),
    .cap_abort (cap_abort),
    .cap_len   (cap_len),
    .cap_delay (cap_delay),
    .cap_busy  (cap_busy),
    .cap_done  (cap_done),
    .tx_count  (tx_count),
    .orx_count (orx_count),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

  always #5 data_clk = ~data_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge data_clk);
    #1;
  endtask

  function automatic logic [11:0] ra(input logic sel, input int idx, input logic w);
    logic [9:0] i10;
    i10 = 10'(idx);
    return {sel, i10, w};
  endfunction

  task automatic start(input logic [10:0] len, input logic [15:0] dly);
    cap_len = len;
    cap_delay = dly;
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
  endtask

  task automatic idle_inputs();
    tx_valid = 1'b0;
    orx_valid = 1'b0;
    cap_abort = 1'b0;
    cap_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!cap_done && n < 100) begin
      tick();
      n++;
    end
    chk(tag, cap_done, 1);
  endtask

  task automatic read_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    rd_addr = a;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    chk({tag, "_valid"}, rd_valid, 1);
    chk(tag, rd_data, exp);
  endtask

  logic [11:0] pa [4];
  logic [31:0] pe [4];

  initial begin
    data_rstn = 1'b0;
    tx_in_0 = '0; tx_in_1 = '0; orx_in_0 = '0; orx_in_1 = '0;
    tx_valid = 0; orx_valid = 0; cap_start = 0; cap_abort = 0;
    cap_len = '0; cap_delay = '0; rd_req = 0; rd_addr = '0;
    tick(); tick();
    chk("rst_busy", cap_busy, 0);
    chk("rst_done", cap_done, 0);
    chk("rst_txcnt", tx_count, 0);
    chk("rst_orxcnt", orx_count, 0);
    chk("rst_rdvalid", rd_valid, 0);
    chk("rst_rddata", rd_data, 0);
    data_rstn = 1'b1;
    tick();

    // ---- basic capture, len 4, no delay ----
    start(11'd4, 16'd0);
    chk("basic_busy", cap_busy, 1);
    for (int k = 0; k < 6; k++) begin
      tx_valid = 1; orx_valid = 1;
      tx_in_0 = k; tx_in_1 = 32'h100 + k;
      orx_in_0 = 32'h200 + k; orx_in_1 = 32'h300 + k;
      tick();
    end
    idle_inputs();
    wait_done("basic_done");
    chk("basic_txcnt", tx_count, 4);
    chk("basic_orxcnt", orx_count, 4);
    tick(); tick();
    chk("basic_idle_busy", cap_busy, 0);
    chk("basic_done_sticky", cap_done, 1);
    read_chk("basic_tx2_i", ra(0, 2, 0), 32'd2);
    read_chk("basic_tx2_q", ra(0, 2, 1), 32'h102);
    read_chk("basic_orx3_q", ra(1, 3, 1), 32'h303);
    read_chk("basic_orx0_i", ra(1, 0, 0), 32'h200);

    // ---- trigger delay 3 ----
    start(11'd4, 16'd3);
    chk("dly_busy", cap_busy, 1);
    chk("dly_done_clr", cap_done, 0);
    for (int k = 0; k < 10; k++) begin
      tx_valid = 1; orx_valid = 1;
      tx_in_0 = 32'h1000 + k; orx_in_0 = 32'h2000 + k;
      tick();
    end
    idle_inputs();
    wait_done("dly_done");
    read_chk("dly_tx0", ra(0, 0, 0), 32'h1003);
    read_chk("dly_orx0", ra(1, 0, 0), 32'h2003);
    read_chk("dly_tx3", ra(0, 3, 0), 32'h1006);

    // ---- unequal rates, len 8 ----
    start(11'd8, 16'd0);
    for (int k = 0; k < 30; k++) begin
      tx_valid = 1; tx_in_0 = k;
      orx_valid = (k % 3 == 0); orx_in_0 = 32'h500 + k;
      tick();
      if (k == 10) begin
        chk("rate_txsat", tx_count, 8);
        chk("rate_orxcnt", orx_count, 4);
        chk("rate_notdone", cap_done, 0);
      end
      if (k == 20) chk("rate_notdone2", cap_done, 0);
    end
    idle_inputs();
    chk("rate_done", cap_done, 1);
    chk("rate_txcnt", tx_count, 8);
    chk("rate_orxcnt_end", orx_count, 8);
    read_chk("rate_orx7", ra(1, 7, 0), 32'h515);

    // ---- full depth (cap_len 0) with one extra beat ----
    start(11'd0, 16'd0);
    for (int k = 0; k < 1025; k++) begin
      tx_valid = 1; orx_valid = 1;
      tx_in_0 = 32'hA000 + k; tx_in_1 = 32'hB000 + k; orx_in_0 = 32'hC000 + k;
      tick();
    end
    idle_inputs();
    wait_done("full_done");
    chk("full_txcnt", tx_count, 1024);
    chk("full_orxcnt", orx_count, 1024);
    read_chk("full_tx0", ra(0, 0, 0), 32'hA000);
    read_chk("full_tx1023", ra(0, 1023, 0), 32'hA3FF);
    read_chk("full_tx1023_q", ra(0, 1023, 1), 32'hB3FF);
    read_chk("full_orx0", ra(1, 0, 0), 32'hC000);

    // ---- abort mid-capture ----
    start(11'd8, 16'd0);
    for (int k = 0; k < 3; k++) begin
      tx_valid = 1; orx_valid = 1;
      tx_in_0 = 32'h600 + k; orx_in_0 = 32'h600 + k;
      tick();
    end
    tx_valid = 0; orx_valid = 0;
    cap_abort = 1;
    tick();
    cap_abort = 0;
    chk("abort_busy", cap_busy, 0);
    chk("abort_done", cap_done, 0);
    chk("abort_txcnt", tx_count, 3);
    tick(); tick();
    chk("abort_done_stays", cap_done, 0);

    // ---- restart; a second cap_start while busy is ignored ----
    start(11'd2, 16'd0);
    tx_valid = 1; orx_valid = 1;
    tx_in_0 = 32'h700; orx_in_0 = 32'h800;
    cap_start = 1; cap_len = 11'd6;
    tick();
    cap_start = 0;
    chk("busy_start_ign", tx_count, 1);
    tx_in_0 = 32'h701; orx_in_0 = 32'h801;
    tick();
    idle_inputs();
    wait_done("restart_done");
    chk("restart_txcnt", tx_count, 2);

    // ---- back-to-back reads ----
    pa[0] = ra(0, 0, 0); pe[0] = 32'h700;
    pa[1] = ra(0, 1, 0); pe[1] = 32'h701;
    pa[2] = ra(0, 2, 0); pe[2] = 32'h602;
    pa[3] = ra(0, 3, 0); pe[3] = 32'hA003;
    for (int i = 0; i < 6; i++) begin
      rd_req = (i < 4);
      rd_addr = (i < 4) ? pa[i] : '0;
      tick();
      chk($sformatf("pipe_valid%0d", i), rd_valid, (i >= 1 && i <= 4));
      if (i >= 1 && i <= 4) chk($sformatf("pipe_data%0d", i - 1), rd_data, pe[i-1]);
    end

    // ---- async reset between request and response ----
    rd_addr = ra(0, 0, 0);
    rd_req = 1;
    tick();
    rd_req = 0;
    #2 data_rstn = 0;
    #1;
    chk("arst_txcnt", tx_count, 0);
    chk("arst_done", cap_done, 0);
    tick();
    chk("arst_rdvalid", rd_valid, 0);
    data_rstn = 1;
    tick();
    chk("arst_rdvalid2", rd_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dpd_capture_buffer.md
Name: dpd_capture_buffer

Overview:
- Data-clock-side capture engine for DPD adaptation. It snapshots actuator output samples (tx) and the observation-receiver samples (orx) into two on-chip buffers.
- It answers read requests coming back from the processor-side command path.
- It is the return-direction counterpart of the LUT-config path: LUT words flow into the actuator, and captured samples flow out to software.
- It sits beside the actuator in the data_clk domain. A command decoder drives its control and read ports; its read responses feed the data_clk→up_clk return FIFO.

Parameters:
- BUF_ADDR_WIDTH, 10, log2 capture depth in 2-sample beats (depth 1024 beats = 2048 samples per path).
- DELAY_WIDTH, 16, width of the trigger-delay counter.

Ports:
- data_clk  in  1  sample/control clock.
- data_rstn  in  1  reset, asynchronous, active-low.
- tx_in_0  in  32  {tx_i[2n+1],tx_i[2n]}.
- tx_in_1  in  32  {tx_q[2n+1],tx_q[2n]}.
- tx_valid  in  1  tx beat qualifier.
- orx_in_0  in  32  {orx_i[2n+1],orx_i[2n]}.
- orx_in_1  in  32  {orx_q[2n+1],orx_q[2n]}.
- orx_valid  in  1  orx beat qualifier.
- cap_start  in  1  single-cycle pulse that arms a capture.
- cap_abort  in  1  single-cycle pulse that aborts a capture.
- cap_len  in  BUF_ADDR_WIDTH+1  beats to capture per path; 0 means full depth.
- cap_delay  in  DELAY_WIDTH  tx_valid beats to skip after arming.
- cap_busy  out  1  high in ARMED or CAPTURE.
- cap_done  out  1  sticky; cleared by cap_start.
- tx_count  out  BUF_ADDR_WIDTH+1  tx beats written so far.
- orx_count  out  BUF_ADDR_WIDTH+1  orx beats written so far.
- rd_req  in  1  single-cycle read request.
- rd_addr  in  BUF_ADDR_WIDTH+2  read address: [MSB]=0 tx / 1 orx; [0]=0 I word / 1 Q word; middle bits = beat index.
- rd_data  out  32  read word.
- rd_valid  out  1  one-cycle response strobe.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Buffer RAM contents are not reset.
- States:
  - IDLE: cap_start → latch cap_len (0→2^BUF_ADDR_WIDTH) and cap_delay; clear counts and cap_done. Go to ARMED if the latched delay ≠ 0, otherwise CAPTURE.
  - ARMED: decrement the delay counter on each tx_valid; go to CAPTURE in the cycle after the counter reaches 0. orx is not written in ARMED.
  - CAPTURE:
    - Each tx_valid writes {tx_in_1,tx_in_0} at tx_count, then tx_count++.
    - Each orx_valid writes {orx_in_1,orx_in_0} at orx_count, then orx_count++.
    - A path stops writing once its count equals the latched length, even if valid continues.
    - When both counts equal the length → DONE.
  - DONE: cap_done=1 and cap_busy=0 in the same cycle as entry; go to IDLE the following cycle. cap_done stays high until the next cap_start.
- cap_start while busy: ignored.
- cap_abort in ARMED/CAPTURE: go to IDLE next cycle; cap_done stays 0; counts hold their values. cap_abort has priority over a same-cycle DONE transition.
- Simultaneous tx_valid and orx_valid: both are written in the same cycle, because the two buffers are independent RAMs.
- Reads:
  - Latency is fixed at 2 cycles: rd_req at cycle t → rd_valid and rd_data at t+2 (RAM read plus output register).
  - Reads are allowed in any state and return the current RAM contents. A read of an address being written in the same cycle returns old data.
  - Back-to-back rd_req every cycle is supported, giving one response per request in order.
  - Beat index ≥ the latched length returns stale RAM contents; there is no error signalling.
- Word selection: rd_addr[0]=0 returns bits [31:0] of the stored beat (I pair); rd_addr[0]=1 returns bits [63:32] (Q pair).
- Async reset mid-capture: outputs clear immediately. Any rd_valid in the pipeline is dropped.

Decomposition:
- Shared package dpd_cap_pkg holds:
  - state encoding (IDLE, ARMED, CAPTURE, DONE);
  - constants SEL_TX=0 and SEL_ORX=1;
  - constants WORD_I=0 and WORD_Q=1.
- Sub-module dpd_cap_ram: simple dual-port RAM, 64-bit by 2^BUF_ADDR_WIDTH, one write port and a registered read port. It is instantiated twice, once for tx and once for orx.

Test Plan:
- Basic capture: cap_len=4, cap_delay=0, tx and orx valid every cycle with tx_in_0=beat k → cap_done rises 4 beats after start, counts=4. Reading addr {0,k,0} returns k; reading with rd_addr[0]=1 returns tx_in_1 of beat k.
- Delay: cap_delay=3 with tx beats 0..9 → tx buffer[0] holds beat 3. orx beats presented during ARMED are not stored.
- Unequal rates: tx_valid every cycle, orx_valid every 3rd cycle, cap_len=8 → tx_count saturates at 8; cap_done asserts only when orx_count reaches 8.
- Full depth: cap_len=0 → exactly 1024 beats captured per path. An extra valid beat does not overwrite buffer[0].
- Abort and restart: cap_abort mid-CAPTURE → busy falls, done stays 0. cap_start during busy is ignored; a fresh cap_start afterwards captures normally.
- Read pipeline: rd_req on 4 consecutive cycles → 4 rd_valid pulses, each 2 cycles later and in order. Async reset between request and response → no rd_valid appears.
